uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter. It drives the TX line and answers the tx_start/tx_done handshake issued by the command/ALU interface circuit, which is the data source. Bit timing comes from the shared 16x-oversampling baud tick generator also used by the UART receiver. The frame is start bit, NB_DATA data bits LSB first, an optional parity bit, then the stop period.

Parameters:
NB_DATA, 8, data bits per frame
SB_TICK, 16, baud ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVERSAMPLE, 16, baud ticks per start, data and parity bit
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset
i_tick  input  1  baud tick, one-cycle pulse at 16x baud rate
i_data  input  NB_DATA  byte to send; sampled only on the accept cycle
i_tx_start  input  1  send request, level; held high by the source until it sees o_tx_done
o_tx  output  1  serial line, idle high
o_tx_done  output  1  one-cycle pulse at end of frame
o_busy  output  1  high from the cycle after accept until the cycle o_tx_done asserts

Behaviour:
- Reset: i_rst synchronous, active-high; clock i_clk.
  - Reset values: o_tx=1, o_tx_done=0, o_busy=0, state=IDLE, tick counter=0, bit counter=0, shift register=0, armed=1.
  - Reset mid-frame aborts the frame. o_tx is high on the next cycle and no o_tx_done is issued.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept rule:
  - A request is accepted on the clock edge where state==IDLE, i_tx_start==1 and armed==1.
  - On accept: i_data is latched into the shift register, the parity bit is computed from i_data, armed is cleared, state becomes START and tick_cnt is set to 0.
  - armed is set again on any cycle with i_tx_start==0.
  - A level held high after o_tx_done therefore never starts a second frame. The source drops i_tx_start one cycle after the done pulse.
- START:
  - o_tx=0 from the cycle after accept.
  - tick_cnt increments on each i_tick.
  - On the i_tick where tick_cnt==OVERSAMPLE-1: tick_cnt=0, bit_cnt=0, state=DATA.
- DATA:
  - o_tx = shift[0].
  - On the i_tick where tick_cnt==OVERSAMPLE-1: shift right by 1 and bit_cnt++.
  - When bit_cnt==NB_DATA-1 at that tick, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - o_tx = XOR of the latched data for even, inverted XOR for odd.
  - Lasts OVERSAMPLE ticks, then STOP.
- STOP:
  - o_tx=1.
  - On the i_tick where tick_cnt==SB_TICK-1: state=IDLE and o_tx_done=1 for exactly one cycle, concurrent with o_busy falling.
- Bit duration:
  - Every bit is exactly OVERSAMPLE i_tick pulses; the stop period is SB_TICK pulses.
  - The start bit may additionally include up to one tick period of clocks before the first counted tick, since the accept is not tick-aligned.
- No i_tick: state and o_tx hold indefinitely. Only i_rst exits.
- i_tick coincident with accept: that tick is not counted.
- i_tx_start and i_data changes while busy are ignored.
- A new accept is possible at the earliest on the cycle after o_tx_done, and only if armed has been set by i_tx_start low.

Test Plan:
- Tick every 4 clocks, PARITY=0, i_data=8'h35, i_tx_start held:
  - o_tx carries 0,1,0,1,0,1,1,0,0 then 1 (stop); each bit 16 ticks = 64 clocks, stop 64 clocks.
  - Exactly one o_tx_done pulse; o_busy high for the whole frame.
- Keep i_tx_start high 10 cycles after o_tx_done: no second frame, o_tx stays 1, o_busy=0.
  - Then drop it low 1 cycle and raise it with 8'hA0: a second frame starts with bits 0,0,0,0,0,1,0,1.
- PARITY=1 with 8'h07: parity bit 1. PARITY=2 with 8'h07: parity bit 0.
  - Frame is 11 bits total with SB_TICK=16; o_tx_done occurs after 176 ticks.
- Assert i_rst for 1 cycle during data bit 3 of 8'hFF: o_tx=1 and o_busy=0 next cycle, no o_tx_done.
  - A following request transmits a full, correct frame.
- Stop i_tick for 100 cycles mid data bit 2: o_tx holds its value.
  - On tick resume the bit completes after the remaining ticks; total ticks per bit is still 16.
- SB_TICK=32: stop period lasts 32 ticks; o_tx_done fires on the 32nd stop tick.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity, stop period.
// Latency: line drops to the start bit one cycle after accept; o_tx_done pulses on the final stop tick edge.
// Backpressure: i_tx_start is a level handshake; a held level cannot retrigger until it has been seen low once.
module uart_tx #(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_start,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    // Counter sized for the longer of a bit period and the stop period.
    localparam int TMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(NB_DATA + 1);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t             state, state_nx;
    logic [TW-1:0]      tick_cnt, tick_cnt_nx;
    logic [BW-1:0]      bit_cnt, bit_cnt_nx;
    logic [NB_DATA-1:0] shift, shift_nx;
    logic               par_bit, par_bit_nx;
    logic               armed, armed_nx;
    logic               tx_nx, done_nx, busy_nx;

    // Next-state, counters and the values the registered outputs take next cycle.
    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift;
        par_bit_nx  = par_bit;
        armed_nx    = i_tx_start ? armed : 1'b1;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                // A tick coincident with accept is deliberately not counted.
                if (i_tx_start && armed) begin
                    shift_nx    = i_data;
                    par_bit_nx  = (^i_data) ^ (PARITY == 2);
                    armed_nx    = 1'b0;
                    tick_cnt_nx = '0;
                    state_nx    = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nx = '0;
                        bit_cnt_nx  = '0;
                        state_nx    = DATA;
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nx = '0;
                        shift_nx    = shift >> 1;
                        bit_cnt_nx  = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_nx = (PARITY != 0) ? PAR : STOP;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
            end
            PAR: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nx = '0;
                        state_nx    = STOP;
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == SB_LAST) begin
                        tick_cnt_nx = '0;
                        state_nx    = IDLE;
                        done_nx     = 1'b1;
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Line level follows the state being entered so o_tx can be a plain register.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            PAR:     tx_nx = par_bit_nx;
            default: tx_nx = 1'b1;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State and output registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            armed     <= 1'b1;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            shift     <= shift_nx;
            par_bit   <= par_bit_nx;
            armed     <= armed_nx;
            o_tx      <= tx_nx;
            o_tx_done <= done_nx;
            o_busy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity / even / odd with 2 stop bits).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Bit timing is checked by counting the ticks the DUT actually sees.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       tick_en;
    logic [7:0] data;
    logic [2:0] start_v;
    logic [2:0] tx_v;
    logic [2:0] done_v;
    logic [2:0] busy_v;

    int total = 0;
    int bad   = 0;
    bit busy_drop;
    bit early_done;

    uart_tx #(.NB_DATA(8), .SB_TICK(16), .OVERSAMPLE(16), .PARITY(0)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_tx_start(start_v[0]),
        .o_tx(tx_v[0]), .o_tx_done(done_v[0]), .o_busy(busy_v[0])
    );

    uart_tx #(.NB_DATA(8), .SB_TICK(16), .OVERSAMPLE(16), .PARITY(1)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_tx_start(start_v[1]),
        .o_tx(tx_v[1]), .o_tx_done(done_v[1]), .o_busy(busy_v[1])
    );

    uart_tx #(.NB_DATA(8), .SB_TICK(32), .OVERSAMPLE(16), .PARITY(2)) dut_o (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_tx_start(start_v[2]),
        .o_tx(tx_v[2]), .o_tx_done(done_v[2]), .o_busy(busy_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every 4 clocks while enabled.
    initial begin
        int ph;
        ph   = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                ph   = (ph + 1) % 4;
                tick = (ph == 0);
            end else begin
                tick = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge at which a tick is pending for the coming rising edge.
    task automatic next_tick(input int inst, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_v[inst] !== 1'b1) busy_drop = 1'b1;
            if (done_v[inst] !== 1'b0) early_done = 1'b1;
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Issue a request and check the whole frame tick by tick; leaves i_tx_start high.
    task automatic run_frame(input int inst, input logic [7:0] d, input bit has_par,
                             input logic par, input int sb, input int stall_at, input string tag);
        logic [9:0] bits;
        int         nbits;
        int         tcount;
        bit         ok;
        bit         held;
        bit         tx_bad;
        bits       = {par, d, 1'b0};
        nbits      = has_par ? 10 : 9;
        tcount     = 0;
        busy_drop  = 1'b0;
        early_done = 1'b0;
        @(posedge clk);
        #1;
        data          = d;
        start_v[inst] = 1'b1;
        @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < 16; k++) begin
                next_tick(inst, ok);
                if (!ok) begin
                    chk({tag, "_tick_timeout"}, 0, 1);
                    return;
                end
                tcount++;
                if (tcount == 1) data = ~d;
                if (k == 0 || k == 15)
                    chk($sformatf("%s_bit%0d_k%0d", tag, b, k), tx_v[inst], bits[b]);
                if (tcount == stall_at) begin
                    tick_en = 1'b0;
                    held    = 1'b1;
                    for (int c = 0; c < 100; c++) begin
                        @(negedge clk);
                        if (tx_v[inst] !== bits[b]) held = 1'b0;
                    end
                    chk({tag, "_stall_hold"}, held, 1);
                    tick_en = 1'b1;
                end
            end
        end
        tx_bad = 1'b0;
        for (int k = 0; k < sb; k++) begin
            next_tick(inst, ok);
            if (!ok) begin
                chk({tag, "_stop_timeout"}, 0, 1);
                return;
            end
            if (tx_v[inst] !== 1'b1) tx_bad = 1'b1;
        end
        chk({tag, "_stop_level"}, tx_bad, 0);
        chk({tag, "_busy_whole_frame"}, busy_drop, 0);
        chk({tag, "_no_early_done"}, early_done, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_v[inst], 1);
        chk({tag, "_busy_fall"}, busy_v[inst], 0);
        chk({tag, "_tx_idle"}, tx_v[inst], 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done_v[inst], 0);
    endtask

    initial begin
        bit ok;
        bit flag;
        rst     = 1'b1;
        tick_en = 1'b1;
        data    = 8'h00;
        start_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", {29'd0, tx_v}, 32'h7);
        chk("reset_done", {29'd0, done_v}, 32'h0);
        chk("reset_busy", {29'd0, busy_v}, 32'h0);

        // 0x35, no parity: line 0,1,0,1,0,1,1,0,0 then stop.
        run_frame(0, 8'h35, 1'b0, 1'b0, 16, -1, "f35");

        // Level still high after done: must not start another frame.
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) flag = 1'b1;
        end
        chk("held_start_no_refire", flag, 0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        run_frame(0, 8'hA0, 1'b0, 1'b0, 16, -1, "fA0");
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;

        // Even parity of 0x07 is 1; odd parity is 0 (with a 32-tick stop period).
        run_frame(1, 8'h07, 1'b1, 1'b1, 16, -1, "even07");
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        run_frame(2, 8'h07, 1'b1, 1'b0, 32, -1, "odd07_sb32");
        @(posedge clk);
        #1;
        start_v[2] = 1'b0;

        // Reset in the middle of data bit 3 of 0xFF.
        @(posedge clk);
        #1;
        data       = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        ok = 1'b1;
        for (int t = 0; t < 72 && ok; t++) next_tick(0, ok);
        chk("rst_reach_bit3", ok, 1);
        chk("rst_pre_busy", busy_v[0], 1);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_high", tx_v[0], 1);
        chk("rst_busy_low", busy_v[0], 0);
        flag = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) flag = 1'b1;
        end
        chk("rst_no_done_idle", flag, 0);
        run_frame(0, 8'hFF, 1'b0, 1'b0, 16, -1, "after_rst_FF");
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;

        // Tick stall for 100 cycles in data bit 2 (tick 53 of the frame), bit value 1.
        run_frame(0, 8'h04, 1'b0, 1'b0, 16, 53, "stall04");
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
